// File: rtl/axi_read_slave_pkg.sv
// Shared AXI encodings and FSM state type for the read-slave memory model.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

endpackage

// File: rtl/axi_read_slave_if.sv
// AXI4 read address + read data channel bundle with master/slave views.
interface axi_read_slave_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
);
   logic [ID_WIDTH-1:0]   ARID;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic [1:0]            ARBURST;
   logic [3:0]            ARREGION;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [ID_WIDTH-1:0]   RID;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

endinterface

// File: rtl/axi_read_slave_ar_fifo.sv
// Small synchronous FIFO holding accepted AR requests until the FSM pops them.
module axi_ar_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_doPush;
   logic             w_doPop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty  = (r_wrPtr == r_rdPtr);
   assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;
   assign o_data   = r_mem[r_rdPtr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/axi_read_slave.sv
// AXI4 read responder: queues AR requests and streams bursts from an inline
// word-addressed memory that is preloaded through a backdoor write port.
module axi_read_slave
   import axi_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int AR_DEPTH   = 4,
   parameter int MEM_DEPTH  = 128
) (
   input  logic                         clk,
   input  logic                         rst,
   axi_read_slave_if.slave              bus,
   input  logic                         mem_wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
   input  logic [DATA_WIDTH-1:0]        mem_wr_data
);
   localparam int MW         = $clog2(MEM_DEPTH);
   localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int REQ_W      = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   state_t                r_state;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_beatsLeft;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_err;

   logic                  r_rValid;
   logic [DATA_WIDTH-1:0] r_rData;
   logic [ID_WIDTH-1:0]   r_rId;
   logic [1:0]            r_rResp;
   logic                  r_rLast;

   logic [REQ_W-1:0]      w_qData;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_load;
   logic [ID_WIDTH-1:0]   w_qId;
   logic [ADDR_WIDTH-1:0] w_qAddr;
   logic [7:0]            w_qLen;
   logic [2:0]            w_qSize;
   logic [1:0]            w_qBurst;
   logic                  w_popErr;
   logic [ADDR_WIDTH-1:0] w_wordIdx;
   logic                  w_beatErr;
   logic [ADDR_WIDTH-1:0] w_nextAddr;

   axi_ar_fifo #(.WIDTH(REQ_W), .DEPTH(AR_DEPTH)) u_arFifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (bus.ARVALID),
      .i_pop   (w_pop),
      .i_data  ({bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST}),
      .o_data  (w_qData),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign {w_qId, w_qAddr, w_qLen, w_qSize, w_qBurst} = w_qData;

   // Oversized beats and WRAP/reserved bursts poison the whole burst at pop time.
   assign w_popErr   = (w_qSize > 3'(WORD_SHIFT)) | (w_qBurst >= AXI_BURST_WRAP);
   assign w_wordIdx  = r_addr >> WORD_SHIFT;
   assign w_beatErr  = r_err | (32'(w_wordIdx) >= MEM_DEPTH);
   assign w_nextAddr = (r_burst == AXI_BURST_INCR) ? r_addr + (ADDR_WIDTH'(1) << r_size) : r_addr;

   assign w_pop  = (r_state == S_IDLE) & ~w_empty;
   assign w_load = (r_state == S_BUSY) & (~r_rValid | bus.RREADY);

   assign bus.ARREADY = ~w_full;
   assign bus.RVALID  = r_rValid;
   assign bus.RDATA   = r_rData;
   assign bus.RID     = r_rId;
   assign bus.RRESP   = r_rResp;
   assign bus.RLAST   = r_rLast;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_id        <= '0;
         r_addr      <= '0;
         r_beatsLeft <= '0;
         r_size      <= '0;
         r_burst     <= AXI_BURST_FIXED;
         r_err       <= 1'b0;
         r_rValid    <= 1'b0;
         r_rData     <= '0;
         r_rId       <= '0;
         r_rResp     <= AXI_RESP_OKAY;
         r_rLast     <= 1'b0;
      end else begin
         if (r_rValid & bus.RREADY & ~w_load) r_rValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_id        <= w_qId;
                  r_addr      <= w_qAddr;
                  r_beatsLeft <= w_qLen;
                  r_size      <= w_qSize;
                  r_burst     <= w_qBurst;
                  r_err       <= w_popErr;
                  r_state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_load) begin
                  r_rData     <= w_beatErr ? '0 : r_mem[w_wordIdx[MW-1:0]];
                  r_rId       <= r_id;
                  r_rResp     <= w_beatErr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  r_rLast     <= (r_beatsLeft == 8'd0);
                  r_rValid    <= 1'b1;
                  r_addr      <= w_nextAddr;
                  r_beatsLeft <= r_beatsLeft - 8'd1;
                  if (r_beatsLeft == 8'd0) r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Memory is deliberately not reset so preloaded contents survive a reset.
   always_ff @(posedge clk) begin
      if (mem_wr_en) r_mem[mem_wr_addr] <= mem_wr_data;
   end

endmodule

// File: tb/tb_axi_read_slave.sv
// Self-checking bench for axi_read_slave: directed AXI read scenarios plus a
// randomized phase, all checked against a burst-level reference model.
module tb_axi_read_slave;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        mem_wr_en;
   logic [6:0]  mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic        readyFixed;
   logic        randMode;
   logic        randBit;

   int          testCount = 0;
   int          failCount = 0;
   int          beatsSeen = 0;

   logic [63:0] modelMem [128];
   beat_t       expQ [$];

   axi_read_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(10), .DATA_WIDTH(64)) bus ();

   axi_read_slave #(
      .ID_WIDTH(4), .ADDR_WIDTH(10), .DATA_WIDTH(64), .AR_DEPTH(4), .MEM_DEPTH(128)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data)
   );

   assign bus.RREADY = randMode ? randBit : readyFixed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Random RREADY pattern, changed just after each rising edge.
   always @(posedge clk) begin
      #1 randBit = 1'($urandom);
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] check %s failed", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expand one AR into the beats the slave must return, straight from the burst rules.
   function automatic void addExpected(input logic [3:0] id, input logic [9:0] addr,
                                       input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
      int    a;
      int    idx;
      bit    bad;
      bit    err;
      beat_t b;
      a   = int'(addr);
      bad = (size > 3) || (burst >= 2);
      for (int i = 0; i <= int'(len); i++) begin
         idx    = a / 8;
         err    = bad || (idx >= 128);
         b.id   = id;
         b.data = err ? 64'd0 : modelMem[idx];
         b.resp = err ? 2'b10 : 2'b00;
         b.last = (i == int'(len));
         expQ.push_back(b);
         if (burst == 2'b01) a = (a + (1 << size)) % 1024;
      end
   endfunction

   // Every accepted R beat must be the next one the model predicts.
   always @(negedge clk) begin
      beat_t e;
      if (!rst && bus.RVALID && bus.RREADY) begin
         checkOutput("beatExpected", 64'(expQ.size() > 0), 64'd1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("RDATA", bus.RDATA, e.data);
            checkOutput("RID", 64'(bus.RID), 64'(e.id));
            checkOutput("RRESP", 64'(bus.RRESP), 64'(e.resp));
            checkOutput("RLAST", 64'(bus.RLAST), 64'(e.last));
         end
         beatsSeen++;
      end
   end

   task automatic applyStimulus(input logic [3:0] id, input logic [9:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
      bit ok;
      ok           = 1'b0;
      bus.ARID     = id;
      bus.ARADDR   = addr;
      bus.ARLEN    = len;
      bus.ARSIZE   = size;
      bus.ARBURST  = burst;
      bus.ARREGION = 4'($urandom);
      bus.ARVALID  = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (bus.ARREADY) begin
            ok = 1'b1;
            addExpected(id, addr, len, size, burst);
            tick();
            break;
         end
         tick();
      end
      bus.ARVALID = 1'b0;
      checkOutput("arAccepted", 64'(ok), 64'd1);
   endtask

   task automatic waitDrain(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (expQ.size() == 0 && !bus.RVALID) break;
         tick();
      end
      checkOutput("drainLeft", 64'(expQ.size()), 64'd0);
   endtask

   task automatic waitValid(output int cycles);
      cycles = 0;
      while (!bus.RVALID && cycles < 50) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      int n;
      int accepted;
      int seenBefore;
      bus.ARVALID  = 1'b0;
      bus.ARID     = '0;
      bus.ARADDR   = '0;
      bus.ARLEN    = '0;
      bus.ARSIZE   = '0;
      bus.ARBURST  = '0;
      bus.ARREGION = '0;
      mem_wr_en    = 1'b0;
      mem_wr_addr  = '0;
      mem_wr_data  = '0;
      readyFixed   = 1'b0;
      randMode     = 1'b0;
      rst          = 1'b1;
      tick();
      tick();

      // Reset values
      checkOutput("rstRVALID", 64'(bus.RVALID), 64'd0);
      checkOutput("rstARREADY", 64'(bus.ARREADY), 64'd1);
      checkOutput("rstRDATA", bus.RDATA, 64'd0);
      checkOutput("rstRID", 64'(bus.RID), 64'd0);
      checkOutput("rstRRESP", 64'(bus.RRESP), 64'd0);
      checkOutput("rstRLAST", 64'(bus.RLAST), 64'd0);
      rst = 1'b0;
      tick();

      // Backdoor preload: A0..A3 at the bottom, random words elsewhere.
      for (int i = 0; i < 128; i++) begin
         modelMem[i] = (i < 4) ? (64'hA0 + 64'(i)) : {$urandom, $urandom};
         mem_wr_en   = 1'b1;
         mem_wr_addr = 7'(i);
         mem_wr_data = modelMem[i];
         tick();
      end
      mem_wr_en = 1'b0;
      tick();

      // INCR burst: first-beat latency and back-to-back beats.
      readyFixed = 1'b1;
      applyStimulus(4'd5, 10'h000, 8'd3, 3'd3, 2'b01);
      waitValid(n);
      checkOutput("firstBeatLatency", 64'(n), 64'd2);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("sustainedRVALID", 64'(bus.RVALID), 64'd1);
      end
      waitDrain(100);

      // FIXED burst repeats the same word.
      applyStimulus(4'd6, 10'h010, 8'd2, 3'd3, 2'b00);
      waitDrain(100);

      // Mid-burst stall: outputs must hold the pending beat.
      applyStimulus(4'd9, 10'h040, 8'd5, 3'd3, 2'b01);
      waitValid(n);
      tick();
      readyFixed = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput("stallRVALID", 64'(bus.RVALID), 64'd1);
         if (expQ.size() > 0) begin
            checkOutput("stallRDATA", bus.RDATA, expQ[0].data);
            checkOutput("stallRID", 64'(bus.RID), 64'(expQ[0].id));
            checkOutput("stallRLAST", 64'(bus.RLAST), 64'(expQ[0].last));
         end
         tick();
      end
      readyFixed = 1'b1;
      waitDrain(100);

      // Back-to-back single-beat ARs with RREADY low: two are absorbed by the
      // FSM (one presented, one in the burst registers) plus four queued.
      readyFixed  = 1'b0;
      accepted    = 0;
      bus.ARVALID = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.ARID    = 4'(k + 1);
         bus.ARADDR  = 10'(k * 8);
         bus.ARLEN   = 8'd0;
         bus.ARSIZE  = 3'd3;
         bus.ARBURST = 2'b01;
         if (!bus.ARREADY) break;
         addExpected(4'(k + 1), 10'(k * 8), 8'd0, 3'd3, 2'b01);
         accepted++;
         tick();
      end
      checkOutput("fullAcceptCount", 64'(accepted), 64'd6);
      checkOutput("fullARREADY", 64'(bus.ARREADY), 64'd0);
      readyFixed = 1'b1;
      n = 0;
      while (!bus.ARREADY && n < 50) begin
         tick();
         n++;
      end
      checkOutput("fullReleased", 64'(bus.ARREADY), 64'd1);
      if (bus.ARREADY) begin
         addExpected(bus.ARID, bus.ARADDR, 8'd0, 3'd3, 2'b01);
         tick();
      end
      bus.ARVALID = 1'b0;
      waitDrain(100);

      // Error bursts and an address wrap at the top of the space.
      applyStimulus(4'd10, 10'h000, 8'd1, 3'd4, 2'b01);
      applyStimulus(4'd11, 10'h008, 8'd1, 3'd3, 2'b10);
      applyStimulus(4'd12, 10'h3F8, 8'd1, 3'd3, 2'b01);
      waitDrain(200);

      // Reset while a beat is pending and two requests are queued.
      readyFixed = 1'b0;
      for (int k = 0; k < 4; k++) applyStimulus(4'(k + 1), 10'(k * 8), 8'd0, 3'd3, 2'b01);
      tick();
      tick();
      rst = 1'b1;
      #1;
      checkOutput("midRstRVALID", 64'(bus.RVALID), 64'd0);
      checkOutput("midRstARREADY", 64'(bus.ARREADY), 64'd1);
      expQ.delete();
      tick();
      rst        = 1'b0;
      readyFixed = 1'b1;
      seenBefore = beatsSeen;
      repeat (20) tick();
      checkOutput("beatsAfterReset", 64'(beatsSeen - seenBefore), 64'd0);

      // Randomized requests with random backpressure.
      randMode = 1'b1;
      for (int k = 0; k < 25; k++) begin
         applyStimulus(4'($urandom), 10'($urandom), 8'($urandom_range(7, 0)),
                       3'($urandom_range(4, 0)), 2'($urandom_range(3, 0)));
      end
      waitDrain(3000);
      randMode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
